// File: rtl/pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_buffer
// Purpose  : Double-buffered RGB pixel-pair store; SPI bytes fill the back
//            bank while the matrix scanner reads the front bank.
// Revision : 1.0  initial release
// ============================================================================
module pixel_frame_buffer #(
  parameter int  DEPTH = 512,
  localparam int C_AW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  input  logic            frame_start,
  input  logic            swap_req,
  input  logic [C_AW-1:0] rd_addr,
  output logic [5:0]      rd_data,
  output logic            frame_ready,
  output logic            front_bank,
  output logic            overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic [C_AW-1:0]   r_wr_ptr,     w_wr_ptr_nxt;
  logic              r_front_bank, w_front_bank_nxt;
  logic              r_frame_ready, w_frame_ready_nxt;
  logic              r_overflow,   w_overflow_nxt;
  logic              w_we;
  logic [C_AW-1:0]   w_wr_addr;
  logic [5:0]        w_wr_word;
  logic              w_last;
  logic [5:0]        r_rd_data;

  // Both banks share one array; the top address bit selects the bank.
  logic [5:0]        r_mem [0:2*DEPTH-1];

  assign w_wr_word = {byte_data[6:4], byte_data[2:0]};
  assign w_last    = (r_wr_ptr == C_AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_front_bank  <= 1'b0;
      r_frame_ready <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_front_bank  <= w_front_bank_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_front_bank_nxt  = r_front_bank;
    w_frame_ready_nxt = r_frame_ready;
    w_overflow_nxt    = r_overflow;
    w_we              = 1'b0;
    w_wr_addr         = r_wr_ptr;

    // frame_start overrides everything, including a pending swap while FULL.
    if (frame_start) begin
      w_state_nxt       = S_FILL;
      w_frame_ready_nxt = 1'b0;
      w_overflow_nxt    = 1'b0;
      w_wr_ptr_nxt      = '0;
      if (byte_valid) begin
        w_we         = 1'b1;
        w_wr_addr    = '0;
        w_wr_ptr_nxt = C_AW'(1);
      end
    end else begin
      case (r_state)
        S_FILL: begin
          if (byte_valid) begin
            w_we = 1'b1;
            if (w_last) begin
              w_wr_ptr_nxt      = '0;
              w_state_nxt       = S_FULL;
              w_frame_ready_nxt = 1'b1;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (byte_valid) begin
            w_overflow_nxt = 1'b1;
          end
          if (swap_req) begin
            w_front_bank_nxt  = ~r_front_bank;
            w_frame_ready_nxt = 1'b0;
            w_state_nxt       = S_FILL;
            w_wr_ptr_nxt      = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Writer only ever targets the back bank, so the displayed frame never tears.
  always_ff @(posedge clk) begin
    if (reset && w_we) begin
      r_mem[{~r_front_bank, w_wr_addr}] <= w_wr_word;
    end
  end

  // Read uses the pre-swap bank select, so a swap edge still returns old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[{r_front_bank, rd_addr}];
    end
  end

  assign rd_data     = r_rd_data;
  assign frame_ready = r_frame_ready;
  assign front_bank  = r_front_bank;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_buffer
// Purpose  : Self-checking bench for pixel_frame_buffer against a frame-level
//            model of the two banks.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_frame_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_start;
  logic       swap_req;
  logic [8:0] rd_addr;
  logic [5:0] rd_data;
  logic       frame_ready;
  logic       front_bank;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: two banks plus written-flags, and the writer's frame status.
  logic [5:0] m_mem [2][512];
  bit         m_vld [2][512];
  int         m_mode;   // 0 idle, 1 filling, 2 full frame waiting
  int         m_ptr;
  int         m_front;
  int         m_ready;
  int         m_ovf;
  logic [5:0] last_word;

  pixel_frame_buffer #(.DEPTH(512)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_start (frame_start),
    .swap_req    (swap_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .front_bank  (front_bank),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input int addr, input logic [5:0] w);
    m_mem[1 - m_front][addr] = w;
    m_vld[1 - m_front][addr] = 1'b1;
  endtask

  // One clock: update the model from the current inputs, clock, then compare.
  task automatic step();
    logic [5:0] exp_rd;
    bit         known;
    logic [5:0] w;
    w = {byte_data[6:4], byte_data[2:0]};
    if (!reset) begin
      m_mode = 0; m_ptr = 0; m_front = 0; m_ready = 0; m_ovf = 0;
      exp_rd = '0; known = 1'b1;
    end else begin
      known  = m_vld[m_front][rd_addr];
      exp_rd = m_mem[m_front][rd_addr];
      if (frame_start) begin
        m_mode = 1; m_ptr = 0; m_ready = 0; m_ovf = 0;
        if (byte_valid) begin
          model_write(0, w);
          m_ptr = 1;
        end
      end else if (m_mode == 2) begin
        if (byte_valid) m_ovf = 1;
        if (swap_req) begin
          m_front = 1 - m_front; m_ready = 0; m_mode = 1; m_ptr = 0;
        end
      end else if (m_mode == 1 && byte_valid) begin
        model_write(m_ptr, w);
        m_ptr++;
        if (m_ptr == 512) begin
          m_ptr = 0; m_mode = 2; m_ready = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("front_bank", front_bank, m_front);
    check("frame_ready", frame_ready, m_ready);
    check("overflow", overflow, m_ovf);
    if (known) check("rd_data", rd_data, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    byte_valid = 1'b1;
    byte_data  = d;
    last_word  = {d[6:4], d[2:0]};
    step();
    byte_valid = 1'b0;
    idle(gap);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; byte_valid = 1'b0; byte_data = '0;
    frame_start = 1'b0; swap_req = 1'b0; rd_addr = '0;
    m_mode = 0; m_ptr = 0; m_front = 0; m_ready = 0; m_ovf = 0;
    last_word = '0;

    // Reset state
    idle(2);
    check("rst_rd_data", rd_data, 0);
    check("rst_front", front_bank, 0);
    reset = 1'b1;
    idle(2);

    // Full frame of 0x71, one byte every 4 clocks
    pulse_frame_start();
    for (int i = 0; i < 512; i++) begin
      send_byte(8'h71, 0);
      if (i == 511) check("ready_after_last", frame_ready, 1);
      else          check("ready_during_fill", frame_ready, 0);
      idle(3);
    end
    check("front_before_swap", front_bank, 0);
    check("ovf_after_fill", overflow, 0);

    pulse_swap();
    check("front_after_swap", front_bank, 1);
    check("ready_after_swap", frame_ready, 0);
    rd_addr = 9'h000;
    step();
    check("rd_0x71", rd_data, 6'b111001);

    // Overflow while full, cleared by frame_start
    for (int i = 0; i < 512; i++) send_byte(8'($urandom), 0);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 0);
    check("ovf_set", overflow, 1);
    pulse_frame_start();
    check("ovf_cleared", overflow, 0);

    // Partial frame with an ignored swap, then restart with 0x07
    for (int i = 0; i < 99; i++) send_byte(8'($urandom), 0);
    swap_req = 1'b1;
    send_byte(8'($urandom), 0);
    swap_req = 1'b0;
    check("swap_ignored_fill", front_bank, 1);
    pulse_frame_start();
    for (int i = 0; i < 511; i++) send_byte(8'h07, 0);
    swap_req = 1'b1;
    send_byte(8'h07, 0);
    swap_req = 1'b0;
    check("swap_on_last_no_toggle", front_bank, 1);
    check("ready_on_last", frame_ready, 1);
    idle(4);
    pulse_swap();
    check("swap_5_later", front_bank, 0);
    for (int i = 0; i < 512; i++) begin
      rd_addr = 9'(i);
      step();
      check("rd_0x07", rd_data, 6'b000111);
    end

    // Read 0x1FF continuously across a swap edge
    for (int i = 0; i < 512; i++) send_byte(8'($urandom), 0);
    rd_addr = 9'h1FF;
    idle(2);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("rd_at_swap_old", rd_data, 6'b000111);
    step();
    check("rd_after_swap_new", rd_data, last_word);

    // Randomized traffic
    for (int i = 0; i < 8000; i++) begin
      reset       = ($urandom_range(0, 1999) != 0);
      byte_valid  = ($urandom_range(0, 1) == 1);
      byte_data   = 8'($urandom);
      frame_start = ($urandom_range(0, 1499) == 0);
      swap_req    = ($urandom_range(0, 19) == 0);
      rd_addr     = 9'($urandom_range(0, 511));
      step();
    end
    reset = 1'b1; byte_valid = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
